// File: rtl/sys_defs.sv
// Shared pipeline types for the completion stage: FU request vectors,
// completion packets and the CDB broadcast record.
package sys_defs;

  localparam int XLEN            = 32;
  localparam int FU_NUM_DEFAULT  = 4;
  localparam int C_WIDTH_DEFAULT = 2;
  localparam int PR_W            = 6;
  localparam int ROB_W           = 5;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MULT   = 2'd1,
    FU_LOAD   = 2'd2,
    FU_BRANCH = 2'd3
  } fu_class_e;

  // Field order puts alu at bit 0 so the packed vector indexes by class number.
  typedef struct packed {
    logic branch;
    logic load;
    logic mult;
    logic alu;
  } FU_STATE_PACKET;

  typedef struct packed {
    logic             valid;
    logic             if_take_branch;
    logic [XLEN-1:0]  target_pc;
    logic [PR_W-1:0]  dest_pr;
    logic [XLEN-1:0]  dest_value;
    logic [ROB_W-1:0] rob_entry;
    logic             halt;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic            valid;
    logic [PR_W-1:0] tag;
    logic [XLEN-1:0] value;
  } CDB_T;

  // Physical register 0 is the architectural zero: it completes but is never broadcast.
  function automatic logic cdb_broadcast(input FU_COMPLETE_PACKET p);
    return p.valid && (p.dest_pr != {PR_W{1'b0}});
  endfunction

endpackage

// File: rtl/complete_rr_arbiter.sv
// Combinational round-robin picker: selects up to C_WIDTH requesters starting
// at i_ptr, filling slots in scan order and reporting the last one picked.
module complete_rr_arbiter
  import sys_defs::*;
#(
  parameter int FU_NUM  = FU_NUM_DEFAULT,
  parameter int C_WIDTH = C_WIDTH_DEFAULT
) (
  input  logic [FU_NUM-1:0]                         i_req,
  input  logic [$clog2(FU_NUM)-1:0]                 i_ptr,
  output logic [FU_NUM-1:0]                         o_grant,
  output logic [C_WIDTH-1:0]                        o_slot_vld,
  output logic [C_WIDTH-1:0][$clog2(FU_NUM)-1:0]    o_slot_idx,
  output logic [$clog2(FU_NUM)-1:0]                 o_last_idx
);

  localparam int PTR_W = $clog2(FU_NUM);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_hit;

  // Each slot takes the first not-yet-granted requester in rotated scan order.
  always_comb begin
    o_grant    = '0;
    o_slot_vld = '0;
    o_slot_idx = '0;
    o_last_idx = '0;
    w_sum      = '0;
    w_idx      = '0;
    w_hit      = 1'b0;
    for (int s = 0; s < C_WIDTH; s++) begin
      for (int k = 0; k < FU_NUM; k++) begin
        w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
        w_idx = (w_sum >= (PTR_W+1)'(FU_NUM)) ? PTR_W'(w_sum - (PTR_W+1)'(FU_NUM))
                                              : PTR_W'(w_sum);
        w_hit = i_req[w_idx] && !o_grant[w_idx] && !o_slot_vld[s];
        o_grant[w_idx] = o_grant[w_idx] | w_hit;
        o_slot_idx[s]  = w_hit ? w_idx : o_slot_idx[s];
        o_last_idx     = w_hit ? w_idx : o_last_idx;
        o_slot_vld[s]  = o_slot_vld[s] | w_hit;
      end
    end
  end

endmodule

// File: rtl/complete_stage.sv
// Completion stage: arbitrates FU results onto C_WIDTH CDB ports, registers
// them toward the ROB/RS/map table and raises taken-branch redirects.
module complete_stage
  import sys_defs::*;
#(
  parameter int FU_NUM  = FU_NUM_DEFAULT,
  parameter int C_WIDTH = C_WIDTH_DEFAULT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  FU_STATE_PACKET                      want_to_complete,
  input  FU_COMPLETE_PACKET [FU_NUM-1:0]      fu_packet_in,
  input  logic                                squash,
  output FU_STATE_PACKET                      complete_stall,
  output FU_COMPLETE_PACKET [C_WIDTH-1:0]     complete_pkt_out,
  output CDB_T [C_WIDTH-1:0]                  cdb_out,
  output logic                                br_resolve_valid,
  output logic [XLEN-1:0]                     br_target_pc
);

  localparam int PTR_W = $clog2(FU_NUM);

  logic [PTR_W-1:0]                  r_rr_ptr;
  logic [FU_NUM-1:0]                 w_want;
  logic [FU_NUM-1:0]                 w_raw_req;
  logic [FU_NUM-1:0]                 w_req;
  logic [FU_NUM-1:0]                 w_grant;
  logic [FU_NUM-1:0]                 w_stall;
  logic [C_WIDTH-1:0]                w_slot_vld;
  logic [C_WIDTH-1:0][PTR_W-1:0]     w_slot_idx;
  logic [PTR_W-1:0]                  w_last_idx;
  logic [PTR_W-1:0]                  w_ptr_next;
  FU_COMPLETE_PACKET [C_WIDTH-1:0]   w_pkt_next;
  CDB_T [C_WIDTH-1:0]                w_cdb_next;
  logic                              w_br_vld_next;
  logic [XLEN-1:0]                   w_br_pc_next;
  logic                              w_br_hit;

  assign w_want = FU_NUM'(want_to_complete);

  // Request qualification; reset and squash both suppress every grant.
  always_comb begin
    w_raw_req = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      w_raw_req[i] = w_want[i] & fu_packet_in[i].valid;
    end
    w_req   = (reset || squash) ? '0 : w_raw_req;
    w_stall = (squash && !reset) ? '0 : (w_raw_req & ~w_grant);
  end

  assign complete_stall = FU_STATE_PACKET'(w_stall);

  complete_rr_arbiter #(
    .FU_NUM  (FU_NUM),
    .C_WIDTH (C_WIDTH)
  ) u_arb (
    .i_req      (w_req),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_slot_vld (w_slot_vld),
    .o_slot_idx (w_slot_idx),
    .o_last_idx (w_last_idx)
  );

  assign w_ptr_next = (w_last_idx == PTR_W'(FU_NUM - 1)) ? '0 : (w_last_idx + PTR_W'(1));

  // Next-cycle slot contents, CDB records and branch redirect.
  always_comb begin
    w_pkt_next    = '0;
    w_cdb_next    = '0;
    w_br_vld_next = 1'b0;
    w_br_pc_next  = br_target_pc;
    w_br_hit      = 1'b0;
    for (int s = 0; s < C_WIDTH; s++) begin
      if (w_slot_vld[s]) begin
        w_pkt_next[s]       = fu_packet_in[w_slot_idx[s]];
        w_cdb_next[s].valid = cdb_broadcast(w_pkt_next[s]);
        w_cdb_next[s].tag   = w_pkt_next[s].dest_pr;
        w_cdb_next[s].value = w_pkt_next[s].dest_value;
        w_br_hit      = (w_slot_idx[s] == PTR_W'(FU_BRANCH)) && w_pkt_next[s].if_take_branch;
        w_br_vld_next = w_br_vld_next | w_br_hit;
        w_br_pc_next  = w_br_hit ? w_pkt_next[s].target_pc : w_br_pc_next;
      end else begin
        w_pkt_next[s] = '0;
        w_cdb_next[s] = '0;
      end
    end
  end

  // Output registers and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      r_rr_ptr         <= '0;
      complete_pkt_out <= '0;
      cdb_out          <= '0;
      br_resolve_valid <= 1'b0;
      br_target_pc     <= reset ? '0 : br_target_pc;
    end else begin
      r_rr_ptr         <= (|w_grant) ? w_ptr_next : r_rr_ptr;
      complete_pkt_out <= w_pkt_next;
      cdb_out          <= w_cdb_next;
      br_resolve_valid <= w_br_vld_next;
      br_target_pc     <= w_br_pc_next;
    end
  end

endmodule

// File: tb/tb_complete_stage.sv
// Directed bench for complete_stage: arbitration order, stalls, CDB
// suppression for PR0, branch redirect, squash and reset behaviour.
module tb_complete_stage;
  import sys_defs::*;

  logic                          clock;
  logic                          reset;
  logic                          squash;
  logic [3:0]                    want_bits;
  FU_STATE_PACKET                want;
  FU_COMPLETE_PACKET [3:0]       fu_in;
  FU_STATE_PACKET                stall;
  logic [3:0]                    stall_bits;
  FU_COMPLETE_PACKET [1:0]       pkt_out;
  CDB_T [1:0]                    cdb;
  logic                          br_vld;
  logic [XLEN-1:0]               br_pc;

  int n_checks = 0;
  int n_errors = 0;

  assign want       = FU_STATE_PACKET'(want_bits);
  assign stall_bits = stall;

  complete_stage dut (
    .clock            (clock),
    .reset            (reset),
    .want_to_complete (want),
    .fu_packet_in     (fu_in),
    .squash           (squash),
    .complete_stall   (stall),
    .complete_pkt_out (pkt_out),
    .cdb_out          (cdb),
    .br_resolve_valid (br_vld),
    .br_target_pc     (br_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr();
    want_bits = 4'b0000;
    fu_in     = '0;
  endtask

  task automatic set_fu(input logic [1:0] i, input logic [5:0] pr, input logic [31:0] val,
                        input logic take, input logic [31:0] pc, input logic halt,
                        input logic [4:0] rob);
    fu_in[i].valid          = 1'b1;
    fu_in[i].if_take_branch = take;
    fu_in[i].target_pc      = pc;
    fu_in[i].dest_pr        = pr;
    fu_in[i].dest_value     = val;
    fu_in[i].rob_entry      = rob;
    fu_in[i].halt           = halt;
    want_bits[i]            = 1'b1;
  endtask

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    clr();
    @(negedge clock);
    set_fu(2'd0, 6'd1, 32'd1, 1'b0, 32'd0, 1'b0, 5'd0);
    #1;
    chk("rst_stall", 64'(stall_bits), 64'h1);
    tick();
    tick();
    chk("rst_pkt0_vld", 64'(pkt_out[0].valid), 64'd0);
    chk("rst_pkt1_vld", 64'(pkt_out[1].valid), 64'd0);
    chk("rst_cdb0_vld", 64'(cdb[0].valid), 64'd0);
    chk("rst_br_vld", 64'(br_vld), 64'd0);
    chk("rst_br_pc", 64'(br_pc), 64'd0);
    chk("rst_ptr", 64'(dut.r_rr_ptr), 64'd0);
    reset = 1'b0;

    // Lone taken branch
    clr();
    set_fu(2'd3, 6'd32, 32'h0, 1'b1, 32'd8, 1'b0, 5'd0);
    #1;
    chk("br_stall", 64'(stall_bits), 64'h0);
    tick();
    chk("br_pkt0_vld", 64'(pkt_out[0].valid), 64'd1);
    chk("br_pkt1_vld", 64'(pkt_out[1].valid), 64'd0);
    chk("br_rob", 64'(pkt_out[0].rob_entry), 64'd0);
    chk("br_cdb0_vld", 64'(cdb[0].valid), 64'd1);
    chk("br_cdb0_tag", 64'(cdb[0].tag), 64'd32);
    chk("br_resolve", 64'(br_vld), 64'd1);
    chk("br_target", 64'(br_pc), 64'd8);
    chk("br_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // All four request; branch is taken but loses arbitration the first cycle
    clr();
    set_fu(2'd0, 6'd1, 32'd11, 1'b0, 32'd0,     1'b0, 5'd1);
    set_fu(2'd1, 6'd2, 32'd22, 1'b0, 32'd0,     1'b0, 5'd2);
    set_fu(2'd2, 6'd3, 32'd33, 1'b0, 32'd0,     1'b0, 5'd3);
    set_fu(2'd3, 6'd4, 32'd44, 1'b1, 32'h40,    1'b0, 5'd4);
    #1;
    chk("all4_stall", 64'(stall_bits), 64'hC);
    tick();
    chk("all4_s0_pr", 64'(pkt_out[0].dest_pr), 64'd1);
    chk("all4_s1_pr", 64'(pkt_out[1].dest_pr), 64'd2);
    chk("all4_cdb1_val", 64'(cdb[1].value), 64'd22);
    chk("all4_br_vld", 64'(br_vld), 64'd0);
    chk("all4_br_pc_hold", 64'(br_pc), 64'd8);
    chk("all4_ptr", 64'(dut.r_rr_ptr), 64'd2);
    #1;
    chk("held_stall", 64'(stall_bits), 64'h3);
    tick();
    chk("held_s0_pr", 64'(pkt_out[0].dest_pr), 64'd3);
    chk("held_s1_pr", 64'(pkt_out[1].dest_pr), 64'd4);
    chk("held_br_vld", 64'(br_vld), 64'd1);
    chk("held_br_pc", 64'(br_pc), 64'h40);
    chk("held_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // ALU writes PR0: reaches ROB, not the CDB
    clr();
    set_fu(2'd0, 6'd0, 32'd5, 1'b0, 32'd0, 1'b0, 5'd5);
    #1;
    chk("pr0_stall", 64'(stall_bits), 64'h0);
    tick();
    chk("pr0_pkt0_vld", 64'(pkt_out[0].valid), 64'd1);
    chk("pr0_value", 64'(pkt_out[0].dest_value), 64'd5);
    chk("pr0_cdb0_vld", 64'(cdb[0].valid), 64'd0);
    chk("pr0_pkt1_vld", 64'(pkt_out[1].valid), 64'd0);
    chk("pr0_ptr", 64'(dut.r_rr_ptr), 64'd1);

    // Walk the pointer to 3, then load+branch wraps around
    clr();
    set_fu(2'd1, 6'd5, 32'd55, 1'b0, 32'd0, 1'b0, 5'd6);
    tick();
    chk("walk_ptr2", 64'(dut.r_rr_ptr), 64'd2);
    clr();
    set_fu(2'd2, 6'd6, 32'd66, 1'b0, 32'd0, 1'b0, 5'd7);
    tick();
    chk("walk_ptr3", 64'(dut.r_rr_ptr), 64'd3);
    clr();
    set_fu(2'd2, 6'd7, 32'd77, 1'b0, 32'd0,   1'b1, 5'd8);
    set_fu(2'd3, 6'd8, 32'd88, 1'b0, 32'h100, 1'b0, 5'd9);
    #1;
    chk("wrap_stall", 64'(stall_bits), 64'h0);
    tick();
    chk("wrap_s0_pr", 64'(pkt_out[0].dest_pr), 64'd8);
    chk("wrap_s1_pr", 64'(pkt_out[1].dest_pr), 64'd7);
    chk("wrap_s1_halt", 64'(pkt_out[1].halt), 64'd1);
    chk("wrap_s0_halt", 64'(pkt_out[0].halt), 64'd0);
    chk("wrap_br_vld", 64'(br_vld), 64'd0);
    chk("wrap_ptr", 64'(dut.r_rr_ptr), 64'd3);

    // Idle cycle holds the pointer
    clr();
    tick();
    chk("idle_pkt0_vld", 64'(pkt_out[0].valid), 64'd0);
    chk("idle_ptr", 64'(dut.r_rr_ptr), 64'd3);

    // Squash with three pending requests
    clr();
    set_fu(2'd0, 6'd9,  32'd1, 1'b0, 32'd0, 1'b0, 5'd10);
    set_fu(2'd1, 6'd10, 32'd2, 1'b0, 32'd0, 1'b0, 5'd11);
    set_fu(2'd2, 6'd11, 32'd3, 1'b0, 32'd0, 1'b0, 5'd12);
    squash = 1'b1;
    #1;
    chk("sq_stall", 64'(stall_bits), 64'h0);
    tick();
    squash = 1'b0;
    chk("sq_pkt0_vld", 64'(pkt_out[0].valid), 64'd0);
    chk("sq_pkt1_vld", 64'(pkt_out[1].valid), 64'd0);
    chk("sq_cdb0_vld", 64'(cdb[0].valid), 64'd0);
    chk("sq_br_vld", 64'(br_vld), 64'd0);
    chk("sq_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Two packets registered, then reset arrives
    clr();
    set_fu(2'd0, 6'd9,  32'd1, 1'b0, 32'd0, 1'b0, 5'd10);
    set_fu(2'd1, 6'd10, 32'd2, 1'b0, 32'd0, 1'b0, 5'd11);
    tick();
    chk("pre_rst_pkt1_vld", 64'(pkt_out[1].valid), 64'd1);
    chk("pre_rst_cdb1_tag", 64'(cdb[1].tag), 64'd10);
    chk("pre_rst_ptr", 64'(dut.r_rr_ptr), 64'd2);
    set_fu(2'd3, 6'd12, 32'd4, 1'b1, 32'h80, 1'b0, 5'd13);
    reset = 1'b1;
    #1;
    chk("mid_rst_stall", 64'(stall_bits), 64'hB);
    tick();
    reset = 1'b0;
    clr();
    chk("mid_rst_pkt0_vld", 64'(pkt_out[0].valid), 64'd0);
    chk("mid_rst_pkt1_vld", 64'(pkt_out[1].valid), 64'd0);
    chk("mid_rst_cdb1_vld", 64'(cdb[1].valid), 64'd0);
    chk("mid_rst_br_vld", 64'(br_vld), 64'd0);
    chk("mid_rst_br_pc", 64'(br_pc), 64'd0);
    chk("mid_rst_ptr", 64'(dut.r_rr_ptr), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/complete_stage.md
COMPLETE_STAGE -- requirements
Module: complete_stage

Interface
REQ-001 Parameter: FU_NUM, 4, number of completing FU classes (0=alu, 1=mult, 2=load, 3=branch).
REQ-002 Parameter: C_WIDTH, 2, completion ports per cycle (CDB width).
REQ-003 clock  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 want_to_complete  input  FU_STATE_PACKET  per-class completion request.
REQ-006 fu_packet_in  input  FU_COMPLETE_PACKET[FU_NUM]  per-class result (valid, if_take_branch, target_pc, dest_pr, dest_value, rob_entry, halt).
REQ-007 squash  input  1  pipeline flush from retire.
REQ-008 complete_stall  output  FU_STATE_PACKET  combinational; 1 = class not granted this cycle, must hold packet.
REQ-009 complete_pkt_out  output  FU_COMPLETE_PACKET[C_WIDTH]  registered completion to ROB.
REQ-010 cdb_out  output  CDB_T[C_WIDTH]  registered tag/value broadcast to RS and map table.
REQ-011 br_resolve_valid / br_target_pc  output  1 / XLEN  registered taken-branch redirect.

Function
REQ-012 A class requests when its want_to_complete bit and fu_packet_in[i].valid are both 1.
REQ-013 Up to C_WIDTH requests granted per cycle, scanning round-robin from rr_ptr upward mod FU_NUM; first grant -> slot 0, second -> slot 1.
REQ-014 complete_stall[i] = request[i] AND NOT grant[i], same cycle; non-requesting classes get 0.
REQ-015 Granted packets appear on complete_pkt_out at the next posedge (latency 1); unused slots valid=0.
REQ-016 cdb_out[s] valid = complete_pkt_out[s].valid AND dest_pr != 0; dest_pr 0 completes to ROB but is never broadcast.
REQ-017 rr_ptr update: any grant -> (index of last granted class + 1) mod FU_NUM; no grant -> hold; wraps 3 -> 0.
REQ-018 Granted branch packet with if_take_branch=1 -> br_resolve_valid=1, br_target_pc=target_pc next cycle; else br_resolve_valid=0.
REQ-019 halt passes through unchanged with its packet.
REQ-020 squash=1: no grants that cycle, complete_stall all 0, next-cycle outputs all invalid, rr_ptr <= 0.
REQ-021 squash and reset simultaneous: reset behaviour applies.
REQ-022 Requests <= C_WIDTH: all granted, no stall, rr_ptr still advances per REQ-017.

Reset
REQ-023 On reset: complete_pkt_out, cdb_out valid = 0; br_resolve_valid = 0; br_target_pc = 0; rr_ptr = 0.
REQ-024 During reset, complete_stall = all 1 for requesting classes (no grants).
REQ-025 Reset mid-operation discards registered completions; no packet reaches outputs in the cycle after reset.

Structure
REQ-026 FU_STATE_PACKET, FU_COMPLETE_PACKET, CDB_T, C_WIDTH and FU_NUM defaults live in the shared sys_defs package.
REQ-027 Round-robin C_WIDTH-of-FU_NUM selection is one sub-module, complete_rr_arbiter (combinational grant + slot indices); rr_ptr register stays in complete_stage.
REQ-028 No other sub-modules; no memory arrays.

Verification
REQ-029 After reset, branch alone requests (dest_pr=32, rob_entry=0, if_take_branch=1, target_pc=8) -> stall.branch=0; next cycle slot0 valid, cdb tag 32, br_resolve_valid=1, br_target_pc=8; rr_ptr=0.
REQ-030 All four request, rr_ptr=0 -> alu slot0, mult slot1, stall load & branch=1; next cycle rr_ptr=2; held requests -> load slot0, branch slot1, rr_ptr=0.
REQ-031 alu completes with dest_pr=0, value 5 -> complete_pkt_out[0].valid=1, cdb_out[0].valid=0.
REQ-032 squash with three requests pending -> complete_stall=0, next cycle all outputs invalid, rr_ptr=0.
REQ-033 rr_ptr=3, load and branch request -> branch slot0, load slot1; rr_ptr becomes 3 (last granted = load, index 2).
REQ-034 reset asserted while two packets registered -> next cycle all outputs invalid, br_resolve_valid=0.
